// File: rtl/bridge_pkg.sv
// Shared types and constants for the SRAM-like bus bridges (data side now,
// instruction side later).
package bridge_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } BridgeState;

  // SRAM-like bus transfer size encoding
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Word handed to the datapath when the watchdog forces a load to complete
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/sel_to_size.sv
// Maps a 4-bit byte-enable pattern to an SRAM-like bus transfer size.
// Single bytes map to SIZE_BYTE and aligned halves to SIZE_HALF. Every other
// pattern, including irregular ones, falls back to SIZE_WORD without
// complaint.
module sel_to_size
  import bridge_pkg::*;
(
  input  logic [3:0] sel,
  output logic [1:0] size
);

  // Decode byte enables into bus size
  always_comb begin
    size = SIZE_WORD;
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      default:                            size = SIZE_WORD;
    endcase
  end

endmodule

// File: rtl/data_sram_like_bridge.sv
// Data-memory bridge: turns the mem stage's single-cycle access into one
// split-transaction SRAM-like bus access. It holds the pipeline with stall_req
// until the access completes, then keeps the load data steady while the whole
// pipeline is frozen.
//
// Optional build macro BRIDGE_TIMEOUT_EN adds a watchdog. If the bus does not
// respond within TIMEOUT_CYCLES cycles, the watchdog completes the access
// itself and sets the sticky bus_err flag. Without this macro the bridge waits
// forever and bus_err is tied low.
module data_sram_like_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              stall_req,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  output logic              bus_err
);

  BridgeState state;
  BridgeState stateNext;
  logic       captureData;
  logic       loadTimeoutData;
  logic       timeoutHit;
  logic [1:0] writeSize;

  sel_to_size uSelToSize (
    .sel  (mem_sel),
    .size (writeSize)
  );

  // The datapath holds address and data stable while stalled, so the bus
  // fields are a straight combinational view of the mem stage.
  assign wr    = |mem_sel;
  assign wdata = mem_wdata;
  assign size  = wr ? writeSize : SIZE_WORD;
  assign addr  = wr ? mem_addr : {mem_addr[ADDR_W-1:2], 2'b00};

  // State register; reset drops any in-flight access (the slave resets too)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state, bus request, stall request and data-capture strobes
  always_comb begin
    stateNext       = state;
    req             = 1'b0;
    captureData     = 1'b0;
    loadTimeoutData = 1'b0;
    stall_req       = (mem_en && (state != DONE)) || (state == DRAIN);
    case (state)
      IDLE: begin
        req = mem_en & ~flush;
        if (mem_en && !flush) begin
          stateNext = addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (flush) begin
          stateNext = IDLE;
        end else if (addr_ok) begin
          stateNext = WAIT;
        end else if (timeoutHit) begin
          stateNext       = DONE;
          loadTimeoutData = 1'b1;
        end
      end
      WAIT: begin
        if (data_ok) begin
          if (flush) begin
            stateNext = IDLE;
          end else begin
            stateNext   = DONE;
            captureData = 1'b1;
          end
        end else if (flush) begin
          stateNext = DRAIN;
        end else if (timeoutHit) begin
          stateNext       = DONE;
          loadTimeoutData = 1'b1;
        end
      end
      DRAIN: begin
        if (data_ok || timeoutHit) begin
          stateNext = IDLE;
        end
      end
      DONE: begin
        if (!pipe_stall || flush) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Load data register: captured on completion, held otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_rdata <= '0;
    end else if (captureData) begin
      mem_rdata <= rdata;
    end else if (loadTimeoutData) begin
      mem_rdata <= TIMEOUT_DATA;
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdCount;
  logic            errFlag;

  // The watchdog restarts on every state change and counts only while the
  // bus owes a response. The hit fires in the TIMEOUT_CYCLES-th cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdCount <= '0;
    end else if (stateNext != state) begin
      wdCount <= '0;
    end else if (state inside {REQ, WAIT, DRAIN}) begin
      wdCount <= wdCount + WD_W'(1);
    end
  end

  assign timeoutHit = (state inside {REQ, WAIT, DRAIN}) && (wdCount == WD_LAST);

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      errFlag <= 1'b0;
    end else if (timeoutHit) begin
      errFlag <= 1'b1;
    end
  end

  assign bus_err = errFlag;
`else
  logic unusedTimeoutCfg;

  // The watchdog limit only matters in the timeout build. It is consumed here
  // so the parameter stays part of the interface in both builds.
  assign unusedTimeoutCfg = (TIMEOUT_CYCLES != 0);
  assign timeoutHit       = 1'b0;
  assign bus_err          = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Bench for data_sram_like_bridge. It plays both the mem stage and the
// SRAM-like slave. Expected outputs come from a transaction-level view:
// request phase, wait phase, completion, hold, flush and drain.
module tb_data_sram_like_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        memEn;
  logic [3:0]  memSel;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        stallReq;
  logic        pipeStall;
  logic        flush;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addrOk;
  logic        dataOk;
  logic [31:0] rdata;
  logic        busErr;

  int          checks   = 0;
  int          errors   = 0;
  int          busTxns  = 0;
  int          expTxns  = 0;
  logic [31:0] expRdata = '0;

  data_sram_like_bridge #(
    .ADDR_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rstN),
    .mem_en     (memEn),
    .mem_sel    (memSel),
    .mem_addr   (memAddr),
    .mem_wdata  (memWdata),
    .mem_rdata  (memRdata),
    .stall_req  (stallReq),
    .pipe_stall (pipeStall),
    .flush      (flush),
    .req        (req),
    .wr         (wr),
    .size       (size),
    .addr       (addr),
    .wdata      (wdata),
    .addr_ok    (addrOk),
    .data_ok    (dataOk),
    .rdata      (rdata),
    .bus_err    (busErr)
  );

  always #5 clk = ~clk;

  // Count address handshakes accepted on the bus
  always @(negedge clk) begin
    if (rstN && req && addrOk) busTxns++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] sel, input logic [31:0] a,
                               input logic [31:0] wd, input logic ps, input logic fl,
                               input logic aok, input logic dok, input logic [31:0] rd);
    memEn     = en;
    memSel    = sel;
    memAddr   = a;
    memWdata  = wd;
    pipeStall = ps;
    flush     = fl;
    addrOk    = aok;
    dataOk    = dok;
    rdata     = rd;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] modelSize(input logic [3:0] sel);
    int ones;
    ones = $countones(sel);
    if (sel == 4'b0000) return 2'd2;
    if (ones == 1) return 2'd0;
    if (sel == 4'b0011 || sel == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] modelAddr(input logic [3:0] sel, input logic [31:0] a);
    return (sel == 4'b0000) ? (a & 32'hFFFF_FFFC) : a;
  endfunction

  task automatic checkBusFields(input string name, input logic [3:0] sel, input logic [31:0] a,
                                input logic [31:0] wd);
    checkOutput({name, ".wr"}, 64'(wr), 64'(sel != 4'b0000));
    checkOutput({name, ".size"}, 64'(size), 64'(modelSize(sel)));
    checkOutput({name, ".addr"}, 64'(addr), 64'(modelAddr(sel, a)));
    checkOutput({name, ".wdata"}, 64'(wdata), 64'(wd));
  endtask

  // Normal access: addr_ok after aDelay request cycles, data_ok dDelay cycles
  // later, then hold cycles of frozen pipeline in DONE
  task automatic doAccess(input string name, input logic [3:0] sel, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int aDelay,
                          input int dDelay, input int hold, input logic endByFlush);
    int last;
    last = aDelay + dDelay;
    for (int c = 0; c <= last; c++) begin
      applyStimulus(1'b1, sel, a, wd, 1'($urandom), 1'b0, c == aDelay, c == last,
                    (c == last) ? rd : $urandom);
      checkOutput({name, ".req"}, 64'(req), 64'(c <= aDelay));
      checkOutput({name, ".stall"}, 64'(stallReq), 64'd1);
      if (c <= aDelay) checkBusFields(name, sel, a, wd);
      tick();
    end
    expTxns++;
    expRdata = rd;
    for (int h = 0; h <= hold; h++) begin
      applyStimulus(1'b1, sel, a, wd, (h < hold) || endByFlush, endByFlush && (h == hold),
                    1'b0, 1'b0, $urandom);
      checkOutput({name, ".done.req"}, 64'(req), 64'd0);
      checkOutput({name, ".done.stall"}, 64'(stallReq), 64'd0);
      checkOutput({name, ".done.rdata"}, 64'(memRdata), 64'(expRdata));
      tick();
    end
  endtask

  // Flush while waiting for data. A late response is drained and discarded.
  task automatic doFlushWait(input string name, input logic [3:0] sel, input logic [31:0] a,
                             input logic [31:0] wd, input int aDelay, input int fOff,
                             input int drain, input logic withData);
    for (int c = 0; c <= aDelay; c++) begin
      applyStimulus(1'b1, sel, a, wd, 1'($urandom), 1'b0, c == aDelay, 1'b0, $urandom);
      checkOutput({name, ".req"}, 64'(req), 64'd1);
      checkOutput({name, ".stall"}, 64'(stallReq), 64'd1);
      checkBusFields(name, sel, a, wd);
      tick();
    end
    expTxns++;
    for (int w = 1; w <= fOff; w++) begin
      applyStimulus(1'b1, sel, a, wd, 1'($urandom), w == fOff, 1'b0, withData && (w == fOff),
                    32'hFFFF_FFFF);
      checkOutput({name, ".wait.req"}, 64'(req), 64'd0);
      checkOutput({name, ".wait.stall"}, 64'(stallReq), 64'd1);
      tick();
    end
    if (!withData) begin
      for (int d = 0; d <= drain; d++) begin
        applyStimulus(1'($urandom), 4'($urandom), $urandom, $urandom, 1'($urandom), 1'b0,
                      1'b0, d == drain, 32'hFFFF_FFFF);
        checkOutput({name, ".drain.req"}, 64'(req), 64'd0);
        checkOutput({name, ".drain.stall"}, 64'(stallReq), 64'd1);
        checkOutput({name, ".drain.rdata"}, 64'(memRdata), 64'(expRdata));
        tick();
      end
    end
    applyStimulus(1'b0, sel, a, wd, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    checkOutput({name, ".after.req"}, 64'(req), 64'd0);
    checkOutput({name, ".after.stall"}, 64'(stallReq), 64'd0);
    checkOutput({name, ".after.rdata"}, 64'(memRdata), 64'(expRdata));
    tick();
  endtask

  // Flush while the address is still unaccepted: the request is withdrawn
  task automatic doFlushReq(input string name, input logic [3:0] sel, input logic [31:0] a,
                            input logic [31:0] wd, input int k);
    for (int c = 0; c <= k; c++) begin
      applyStimulus(1'b1, sel, a, wd, 1'($urandom), c == k, 1'b0, 1'b0, $urandom);
      checkOutput({name, ".req"}, 64'(req), 64'd1);
      checkOutput({name, ".stall"}, 64'(stallReq), 64'd1);
      tick();
    end
    applyStimulus(1'b0, sel, a, wd, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    checkOutput({name, ".after.req"}, 64'(req), 64'd0);
    checkOutput({name, ".after.stall"}, 64'(stallReq), 64'd0);
    checkOutput({name, ".txns"}, 64'(busTxns), 64'(expTxns));
    tick();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 4'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                    1'b0, 1'b0, $urandom);
      checkOutput("idle.req", 64'(req), 64'd0);
      checkOutput("idle.stall", 64'(stallReq), 64'd0);
      checkOutput("idle.rdata", 64'(memRdata), 64'(expRdata));
      tick();
    end
  endtask

  function automatic logic [3:0] randSel();
    if ($urandom_range(0, 1) == 0) return 4'b0000;
    return 4'($urandom);
  endfunction

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    tick();
    checkOutput("reset.rdata", 64'(memRdata), 64'd0);
    checkOutput("reset.busErr", 64'(busErr), 64'd0);
    checkOutput("reset.req", 64'(req), 64'd0);
    checkOutput("reset.stall", 64'(stallReq), 64'd0);
    rstN = 1'b1;

    doAccess("read", 4'b0000, 32'h1000_0006, $urandom, 32'h1122_3344, 0, 3, 0, 1'b0);
    checkOutput("read.final", 64'(expRdata), 64'h1122_3344);
    idleCycles(1);
    doAccess("bytewr", 4'b0100, 32'h0000_0020, $urandom, $urandom, 2, 1, 0, 1'b0);
    doAccess("hold", 4'b0000, 32'h0000_1008, $urandom, 32'hA5A5_0001, 0, 1, 4, 1'b0);
    doAccess("b2b", 4'b0011, 32'h0000_2002, $urandom, $urandom, 0, 1, 0, 1'b0);
    doAccess("oddsel", 4'b0110, 32'h0000_3001, $urandom, $urandom, 1, 2, 1, 1'b0);
    doFlushWait("flushwait", 4'b0000, 32'h0000_4004, $urandom, 1, 2, 3, 1'b0);
    doFlushWait("flushdata", 4'b1111, 32'h0000_5000, $urandom, 0, 1, 0, 1'b1);
    doFlushReq("flushreq", 4'b1100, 32'h0000_6002, $urandom, 2);

    applyStimulus(1'b1, 4'b0000, 32'h7000, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    checkOutput("idleflush.req", 64'(req), 64'd0);
    checkOutput("idleflush.stall", 64'(stallReq), 64'd1);
    tick();
    idleCycles(1);

    doAccess("doneflush", 4'b1000, 32'h0000_8003, $urandom, $urandom, 0, 2, 2, 1'b1);
    doAccess("afterflush", 4'b0000, 32'h0000_9000, $urandom, $urandom, 0, 1, 0, 1'b0);

    applyStimulus(1'b1, 4'b0000, 32'h0000_A000, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, $urandom);
    checkOutput("rstmid.req", 64'(req), 64'd1);
    tick();
    expTxns++;
    applyStimulus(1'b1, 4'b0000, 32'h0000_A000, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    checkOutput("rstmid.stall", 64'(stallReq), 64'd1);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    expRdata = '0;
    idleCycles(1);
    doAccess("postrst", 4'b0000, 32'h0000_B00C, $urandom, $urandom, 1, 1, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        doAccess("rnd", randSel(), $urandom, $urandom, $urandom, $urandom_range(0, 3),
                 $urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
      end else if (kind <= 7) begin
        doFlushWait("rndfw", randSel(), $urandom, $urandom, $urandom_range(0, 2),
                    $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom));
      end else if (kind == 8) begin
        doFlushReq("rndfr", randSel(), $urandom, $urandom, $urandom_range(1, 3));
      end else begin
        idleCycles($urandom_range(1, 2));
      end
    end

    checkOutput("txns", 64'(busTxns), 64'(expTxns));
    checkOutput("busErr", 64'(busErr), 64'd0);

`ifdef BRIDGE_TIMEOUT_EN
    applyStimulus(1'b1, 4'b0000, 32'h0000_C000, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, $urandom);
    tick();
    expTxns++;
    for (int w = 1; w <= TMO; w++) begin
      applyStimulus(1'b1, 4'b0000, 32'h0000_C000, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
      checkOutput("tmo.wait.stall", 64'(stallReq), 64'd1);
      checkOutput("tmo.wait.busErr", 64'(busErr), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 4'b0000, 32'h0000_C000, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    checkOutput("tmo.rdata", 64'(memRdata), 64'hDEAD_BEEF);
    checkOutput("tmo.busErr", 64'(busErr), 64'd1);
    checkOutput("tmo.stall", 64'(stallReq), 64'd0);
    tick();
    idleCycles(0);
    applyStimulus(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("tmo.sticky", 64'(busErr), 64'd1);
    tick();
    checkOutput("tmo.sticky2", 64'(busErr), 64'd1);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("tmo.clear", 64'(busErr), 64'd0);
    checkOutput("tmo.clear.rdata", 64'(memRdata), 64'd0);
    checkOutput("tmo.txns", 64'(busTxns), 64'(expTxns));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
